// File: rtl/sysctl_icap_seq_pkg.sv
// Shared definitions for the sysctl ICAP sequencer: FSM state encoding,
// Spartan-6 sync/type-1 header/command constants and the IPROG ROM lookup.
// A ROM/FIFO word is {ce, write, data[15:0]}; ce/write are active-low.
package sysctl_icap_seq_pkg;

    typedef enum logic [1:0] {StIdle, StRaw, StSeq} state_t;

    localparam logic [15:0] DUMMY_WORD   = 16'hFFFF;
    localparam logic [15:0] SYNC_WORD1   = 16'hAA99;
    localparam logic [15:0] SYNC_WORD2   = 16'h5566;
    localparam logic [15:0] HDR_GENERAL1 = 16'h3261;
    localparam logic [15:0] HDR_GENERAL2 = 16'h3281;
    localparam logic [15:0] HDR_CMD      = 16'h30A1;
    localparam logic [15:0] CMD_IPROG    = 16'h000E;
    localparam logic [15:0] CMD_NOOP     = 16'h2000;

    // {ce, write}: selected+write, or deselected
    localparam logic [1:0] CTL_WRITE    = 2'b00;
    localparam logic [1:0] CTL_DESELECT = 2'b11;

    localparam logic [3:0] SEQ_LAST = 4'd10;

    localparam logic [17:0] IDLE_WORD = {CTL_DESELECT, DUMMY_WORD};

    function automatic logic [17:0] rom_word(input logic [3:0]  idx,
                                             input logic [23:0] addr,
                                             input logic [7:0]  opcode);
        logic [17:0] w;
        case (idx)
            4'd0:    w = {CTL_WRITE, DUMMY_WORD};
            4'd1:    w = {CTL_WRITE, SYNC_WORD1};
            4'd2:    w = {CTL_WRITE, SYNC_WORD2};
            4'd3:    w = {CTL_WRITE, HDR_GENERAL1};
            4'd4:    w = {CTL_WRITE, addr[15:0]};
            4'd5:    w = {CTL_WRITE, HDR_GENERAL2};
            4'd6:    w = {CTL_WRITE, opcode, addr[23:16]};
            4'd7:    w = {CTL_WRITE, HDR_CMD};
            4'd8:    w = {CTL_WRITE, CMD_IPROG};
            4'd9:    w = {CTL_WRITE, CMD_NOOP};
            default: w = {CTL_DESELECT, DUMMY_WORD};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sysctl_icap_fifo.sv
// Small synchronous FIFO for raw CSR-written ICAP words.
// Ports: clk, rst (sync, active-high), push/din, pop/dout (first-word
// fall-through), full, empty. Push on full is dropped unless a pop happens
// in the same cycle; pop on empty is ignored.
module sysctl_icap_fifo #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned WIDTH      = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push, do_pop;

    assign empty   = (count_q == '0);
    // count never exceeds DEPTH, so its MSB alone marks full
    assign full    = count_q[DEPTH_LOG2];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sysctl_icap_seq.sv
// Upstream feeder for the sysctl ICAP writer. Words come from a raw FIFO or
// from the built-in Spartan-6 IPROG (warm reboot) sequence.
// Ports: sys_clk, sys_rst (sync, active-high); raw_we/raw_d/raw_full raw word
// push; start/boot_addr IPROG request; busy, done status; icap_ready/icap_we
// writer handshake; icap_d/icap_ce/icap_write presented word.
module sysctl_icap_seq
    import sysctl_icap_seq_pkg::*;
#(
    parameter int unsigned RAW_DEPTH_LOG2 = 2,
    parameter logic [7:0]  SPI_OPCODE     = 8'h0B
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        raw_we,
    input  logic [17:0] raw_d,
    output logic        raw_full,
    input  logic        start,
    input  logic [23:0] boot_addr,
    output logic        busy,
    output logic        done,
    input  logic        icap_ready,
    output logic        icap_we,
    output logic [15:0] icap_d,
    output logic        icap_ce,
    output logic        icap_write
);

    state_t      state_q;
    logic [3:0]  idx_q;
    logic        pending_q;
    logic [23:0] pend_addr_q;
    logic [23:0] run_addr_q;
    logic        done_q;

    logic [17:0] fifo_dout;
    logic        fifo_empty;
    logic        word_avail;
    logic [17:0] word;

    sysctl_icap_fifo #(
        .DEPTH_LOG2 (RAW_DEPTH_LOG2),
        .WIDTH      (18)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (raw_we),
        .din   (raw_d),
        .pop   ((state_q == StRaw) & icap_we),
        .dout  (fifo_dout),
        .full  (raw_full),
        .empty (fifo_empty)
    );

    always_comb begin
        word_avail = ((state_q == StRaw) & ~fifo_empty) | (state_q == StSeq);
        word       = (state_q == StRaw) ? fifo_dout : rom_word(idx_q, run_addr_q, SPI_OPCODE);
        icap_we    = word_avail & icap_ready & ~sys_rst;
        {icap_ce, icap_write, icap_d} = word_avail ? word : IDLE_WORD;
    end

    assign busy = (state_q != StIdle) | ~fifo_empty | pending_q;
    assign done = done_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            pend_addr_q <= '0;
            run_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start && !pending_q) begin
                pending_q   <= 1'b1;
                pend_addr_q <= boot_addr;
            end
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q <= StRaw;
                    end else if (pending_q) begin
                        // The request is consumed here and its address copied,
                        // so a new start during this run queues the next one.
                        state_q    <= StSeq;
                        idx_q      <= '0;
                        run_addr_q <= pend_addr_q;
                        pending_q  <= 1'b0;
                    end
                end
                StRaw: begin
                    if (fifo_empty) state_q <= StIdle;
                end
                StSeq: begin
                    if (icap_we) begin
                        if (idx_q == SEQ_LAST) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
